// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the memory stage: load/store funct3 encodings
// and the load/store unit handshake states.
package riscv_pkg;

   // Load size/sign encodings (funct3 of LOAD opcodes)
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store size encodings (funct3 of STORE opcodes)
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // IDLE: at most a zero-wait access; WAIT: request held until ready or timeout
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Purely combinational byte-lane logic for the load/store unit: replicates
// store data across lanes, builds byte enables, extracts and extends load
// data from the word bus, and flags accesses that cannot be issued
// (misaligned address or a funct3 that is not legal for the operation).
module lsu_align
   import riscv_pkg::*;
(
   input  logic [1:0]  addr_low,
   input  logic [2:0]  funct3,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] load_data,
   output logic        misalign
);

   logic [31:0] shifted;
   logic        load_bad;
   logic        store_bad;

   // Store path: replicate the operand into every lane it may land in and
   // enable only the addressed bytes; illegal sizes count as misaligned.
   always_comb begin
      wdata     = store_data;
      be        = 4'b0000;
      store_bad = 1'b0;
      case (funct3)
         F3_SB: begin
            wdata = {4{store_data[7:0]}};
            be    = 4'b0001 << addr_low;
         end
         F3_SH: begin
            wdata     = {2{store_data[15:0]}};
            be        = 4'b0011 << addr_low;
            store_bad = addr_low[0];
         end
         F3_SW: begin
            be        = 4'hF;
            store_bad = |addr_low;
         end
         default: store_bad = 1'b1;
      endcase
      if (!mem_write) begin
         be = 4'b0000;
      end
   end

   // Load path: bring the addressed byte/halfword down to bit 0, then
   // sign- or zero-extend; non-loads return zero.
   always_comb begin
      shifted   = load_word >> {addr_low, 3'b000};
      load_data = 32'h0;
      load_bad  = 1'b0;
      case (funct3)
         F3_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LBU: load_data = {24'h0, shifted[7:0]};
         F3_LH: begin
            load_data = {{16{shifted[15]}}, shifted[15:0]};
            load_bad  = addr_low[0];
         end
         F3_LHU: begin
            load_data = {16'h0, shifted[15:0]};
            load_bad  = addr_low[0];
         end
         F3_LW: begin
            load_data = load_word;
            load_bad  = |addr_low;
         end
         default: load_bad = 1'b1;
      endcase
      if (!mem_read) begin
         load_data = 32'h0;
      end
   end

   assign misalign = (mem_read & load_bad) | (mem_write & store_bad);

endmodule

// File: rtl/mem_stage_lsu.sv
// EX/MEM pipeline register plus load/store unit. Holds the instruction in
// MEM, drives a req/ready data-memory port, stalls the front of the pipe
// while an access waits, and converts misaligned or timed-out accesses into
// one-cycle fault pulses that also suppress register write-back.
// The byte-lane logic in lsu_align assumes a 32-bit datapath.
module mem_stage_lsu
   import riscv_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [XLEN-1:0] alu_result_ex,
   input  logic [XLEN-1:0] rdata2_forwarded,
   input  logic [4:0]      rd_exe,
   input  logic [2:0]      funct3_exe,
   input  logic            MemRead_exe,
   input  logic            MemWrite_exe,
   input  logic            RegWrite_exe,
   input  logic            flush_mem,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] alu_result_mem,
   output logic [4:0]      rd_mem,
   output logic            RegWrite_mem,
   output logic [XLEN-1:0] load_data_mem,
   output logic            stall_mem,
   output logic            misalign_mem,
   output logic            bus_err_mem
);

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LAST_C = TO_LAST[CNT_W-1:0];

   logic [XLEN-1:0]  rs2_m;
   logic [2:0]       funct3_m;
   logic             mem_read_m;
   logic             mem_write_m;
   logic             reg_write_m;
   logic             mem_op;
   logic             misalign;
   logic             timeout_hit;
   lsu_state_t       state_q;
   lsu_state_t       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // MEM pipeline register: frozen while stalled so an in-flight access
   // always completes; otherwise loads EX or, on flush, a bubble.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         alu_result_mem <= '0;
         rs2_m          <= '0;
         rd_mem         <= '0;
         funct3_m       <= '0;
         mem_read_m     <= 1'b0;
         mem_write_m    <= 1'b0;
         reg_write_m    <= 1'b0;
      end else if (!stall_mem) begin
         if (flush_mem) begin
            alu_result_mem <= '0;
            rs2_m          <= '0;
            rd_mem         <= '0;
            funct3_m       <= '0;
            mem_read_m     <= 1'b0;
            mem_write_m    <= 1'b0;
            reg_write_m    <= 1'b0;
         end else begin
            alu_result_mem <= alu_result_ex;
            rs2_m          <= rdata2_forwarded;
            rd_mem         <= rd_exe;
            funct3_m       <= funct3_exe;
            mem_read_m     <= MemRead_exe;
            mem_write_m    <= MemWrite_exe;
            reg_write_m    <= RegWrite_exe;
         end
      end
   end

   lsu_align u_align (
      .addr_low   (alu_result_mem[1:0]),
      .funct3     (funct3_m),
      .mem_read   (mem_read_m),
      .mem_write  (mem_write_m),
      .store_data (rs2_m[31:0]),
      .load_word  (dmem_rdata[31:0]),
      .wdata      (dmem_wdata),
      .be         (dmem_be),
      .load_data  (load_data_mem),
      .misalign   (misalign)
   );

   assign mem_op      = mem_read_m | mem_write_m;
   assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST_C);

   // Handshake state and wait counter registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake decisions: issue aligned accesses, hold the request through
   // WAIT, and give up with a bus error once the wait budget is spent.
   // A ready arriving in the last budget cycle still completes the access.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      dmem_req     = 1'b0;
      stall_mem    = 1'b0;
      misalign_mem = 1'b0;
      bus_err_mem  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mem_op) begin
               if (misalign) begin
                  misalign_mem = 1'b1;
               end else begin
                  dmem_req = 1'b1;
                  if (!dmem_ready) begin
                     stall_mem = 1'b1;
                     state_d   = WAIT;
                     cnt_d     = '0;
                  end
               end
            end
         end
         WAIT: begin
            dmem_req  = 1'b1;
            stall_mem = 1'b1;
            if (dmem_ready) begin
               stall_mem = 1'b0;
               state_d   = IDLE;
            end else if (timeout_hit) begin
               dmem_req    = 1'b0;
               stall_mem   = 1'b0;
               bus_err_mem = 1'b1;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dmem_we      = dmem_req & mem_write_m;
   assign dmem_addr    = {alu_result_mem[XLEN-1:2], 2'b00};
   assign RegWrite_mem = reg_write_m & ~misalign_mem & ~bus_err_mem;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases for the documented
// examples followed by randomized traffic, all compared cycle by cycle
// against a behavioural model of the MEM stage.
module tb_mem_stage_lsu;

   localparam int TO = 4;

   typedef struct packed {
      logic        rd_op;
      logic        wr_op;
      logic        regw;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] data;
   } op_t;

   logic        clk;
   logic        reset_n;
   logic [31:0] alu_result_ex;
   logic [31:0] rdata2_forwarded;
   logic [4:0]  rd_exe;
   logic [2:0]  funct3_exe;
   logic        MemRead_exe;
   logic        MemWrite_exe;
   logic        RegWrite_exe;
   logic        flush_mem;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] alu_result_mem;
   logic [4:0]  rd_mem;
   logic        RegWrite_mem;
   logic [31:0] load_data_mem;
   logic        stall_mem;
   logic        misalign_mem;
   logic        bus_err_mem;

   int          checks;
   int          failures;
   op_t         mem_m;
   int          waited;
   logic [31:0] last_wdata;
   logic [3:0]  last_be;
   logic [31:0] last_load;
   int          stall_seen;
   int          mis_seen;
   int          berr_seen;

   mem_stage_lsu #(.XLEN(32), .TIMEOUT_CYC(TO)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .alu_result_ex    (alu_result_ex),
      .rdata2_forwarded (rdata2_forwarded),
      .rd_exe           (rd_exe),
      .funct3_exe       (funct3_exe),
      .MemRead_exe      (MemRead_exe),
      .MemWrite_exe     (MemWrite_exe),
      .RegWrite_exe     (RegWrite_exe),
      .flush_mem        (flush_mem),
      .dmem_ready       (dmem_ready),
      .dmem_rdata       (dmem_rdata),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_wdata       (dmem_wdata),
      .dmem_be          (dmem_be),
      .alu_result_mem   (alu_result_mem),
      .rd_mem           (rd_mem),
      .RegWrite_mem     (RegWrite_mem),
      .load_data_mem    (load_data_mem),
      .stall_mem        (stall_mem),
      .misalign_mem     (misalign_mem),
      .bus_err_mem      (bus_err_mem)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts one comparison and reports it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic op_t mkOp(input logic r, input logic w, input logic rw, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      op_t o;
      o.rd_op = r;
      o.wr_op = w;
      o.regw  = rw;
      o.rd    = rd;
      o.f3    = f3;
      o.addr  = a;
      o.data  = d;
      return o;
   endfunction

   // Access size in bytes, or 0 when funct3 is not legal for the operation.
   function automatic int accessSize(input op_t o);
      if (o.rd_op) begin
         case (o.f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
         endcase
      end else if (o.wr_op) begin
         case (o.f3)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            default: return 0;
         endcase
      end
      return 0;
   endfunction

   function automatic logic isFault(input op_t o);
      int sz;
      sz = accessSize(o);
      if (sz == 0) return 1'b1;
      return (int'(o.addr % 4) % sz) != 0;
   endfunction

   function automatic logic [31:0] expLoad(input op_t o, input logic [31:0] word);
      int      sz;
      longint  span;
      longint  v;
      sz   = accessSize(o);
      span = longint'(1) << (8 * sz);
      v    = longint'(word >> (8 * int'(o.addr % 4))) % span;
      if (o.f3 < 3'd4 && sz < 4 && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   function automatic logic [3:0] expBe(input op_t o);
      int m;
      m = ((1 << accessSize(o)) - 1) << int'(o.addr % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] expWdata(input op_t o);
      case (accessSize(o))
         1:       return 32'(o.data[7:0]) * 32'h01010101;
         2:       return 32'(o.data[15:0]) * 32'h00010001;
         default: return o.data;
      endcase
   endfunction

   // Drives one cycle of inputs, checks every output against the model at
   // the falling edge, then advances the model across the rising edge.
   task automatic applyStimulus(input op_t ex, input logic rdy, input logic [31:0] rdata,
                                input logic flush, input logic rstn);
      logic e_op, e_req, e_stall, e_mis, e_berr, e_done;
      alu_result_ex    = ex.addr;
      rdata2_forwarded = ex.data;
      rd_exe           = ex.rd;
      funct3_exe       = ex.f3;
      MemRead_exe      = ex.rd_op;
      MemWrite_exe     = ex.wr_op;
      RegWrite_exe     = ex.regw;
      flush_mem        = flush;
      dmem_ready       = rdy;
      dmem_rdata       = rdata;
      reset_n          = rstn;
      @(negedge clk);
      e_op    = mem_m.rd_op | mem_m.wr_op;
      e_req   = 1'b0;
      e_stall = 1'b0;
      e_mis   = 1'b0;
      e_berr  = 1'b0;
      e_done  = 1'b0;
      if (e_op && isFault(mem_m)) begin
         e_mis = 1'b1;
      end else if (e_op) begin
         if (rdy) begin
            e_req  = 1'b1;
            e_done = 1'b1;
         end else if (waited == TO) begin
            e_berr = 1'b1;
         end else begin
            e_req   = 1'b1;
            e_stall = 1'b1;
         end
      end
      checkOutput("stall", 32'(stall_mem), 32'(e_stall));
      checkOutput("req", 32'(dmem_req), 32'(e_req));
      checkOutput("misalign", 32'(misalign_mem), 32'(e_mis));
      checkOutput("bus_err", 32'(bus_err_mem), 32'(e_berr));
      checkOutput("regwrite", 32'(RegWrite_mem), 32'(mem_m.regw & ~e_mis & ~e_berr));
      checkOutput("rd_mem", 32'(rd_mem), 32'(mem_m.rd));
      checkOutput("alu_mem", alu_result_mem, mem_m.addr);
      if (e_req) begin
         checkOutput("we", 32'(dmem_we), 32'(mem_m.wr_op));
         checkOutput("addr", dmem_addr, mem_m.addr & 32'hFFFF_FFFC);
         if (mem_m.wr_op) begin
            checkOutput("be", 32'(dmem_be), 32'(expBe(mem_m)));
            checkOutput("wdata", dmem_wdata, expWdata(mem_m));
         end
      end
      if (e_done && mem_m.rd_op) checkOutput("load", load_data_mem, expLoad(mem_m, rdata));
      if (!mem_m.rd_op) checkOutput("load_zero", load_data_mem, 32'h0);
      if (dmem_req && dmem_ready) begin
         last_wdata = dmem_wdata;
         last_be    = dmem_be;
         last_load  = load_data_mem;
      end
      stall_seen += int'(stall_mem);
      mis_seen   += int'(misalign_mem);
      berr_seen  += int'(bus_err_mem);
      @(posedge clk);
      if (!rstn) begin
         mem_m  = '0;
         waited = 0;
      end else if (e_stall) begin
         waited++;
      end else begin
         waited = 0;
         mem_m  = flush ? op_t'('0) : ex;
      end
      #1;
   endtask

   task automatic clearSeen();
      stall_seen = 0;
      mis_seen   = 0;
      berr_seen  = 0;
      last_wdata = '0;
      last_be    = '0;
      last_load  = '0;
   endtask

   // Directed cases for the documented examples, then randomized traffic.
   initial begin
      op_t nop, o;
      int  kind;
      logic rdy, fl, rn;
      checks   = 0;
      failures = 0;
      nop      = '0;
      mem_m    = '0;
      waited   = 0;
      clearSeen();
      alu_result_ex = '0; rdata2_forwarded = '0; rd_exe = '0; funct3_exe = '0;
      MemRead_exe = 1'b0; MemWrite_exe = 1'b0; RegWrite_exe = 1'b0;
      flush_mem = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0; reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(nop, 1'b0, 32'h0, 1'b0, 1'b1);

      clearSeen();
      applyStimulus(mkOp(0, 1, 0, 5'd0, 3'd2, 32'h100, 32'hDEADBEEF), 1'b1, 32'h0, 1'b0, 1'b1);
      applyStimulus(nop, 1'b1, 32'h0, 1'b0, 1'b1);
      checkOutput("sw_be", 32'(last_be), 32'hF);
      checkOutput("sw_wdata", last_wdata, 32'hDEADBEEF);
      checkOutput("sw_nostall", stall_seen, 0);

      clearSeen();
      applyStimulus(mkOp(0, 1, 0, 5'd0, 3'd0, 32'h103, 32'h000000A5), 1'b1, 32'h0, 1'b0, 1'b1);
      applyStimulus(nop, 1'b1, 32'h0, 1'b0, 1'b1);
      checkOutput("sb_be", 32'(last_be), 32'h8);
      checkOutput("sb_wdata", last_wdata, 32'hA5A5A5A5);

      for (int s = 0; s < 2; s++) begin
         clearSeen();
         applyStimulus(mkOp(1, 0, 1, 5'd9, (s == 0) ? 3'd0 : 3'd4, 32'h102, 32'h0), 1'b0, 32'h0080FF00, 1'b0, 1'b1);
         applyStimulus(nop, 1'b0, 32'h0080FF00, 1'b0, 1'b1);
         applyStimulus(nop, 1'b0, 32'h0080FF00, 1'b0, 1'b1);
         applyStimulus(nop, 1'b1, 32'h0080FF00, 1'b0, 1'b1);
         checkOutput("lb_stalls", stall_seen, 2);
         checkOutput("lb_data", last_load, (s == 0) ? 32'hFFFFFF80 : 32'h00000080);
      end

      clearSeen();
      applyStimulus(mkOp(1, 0, 1, 5'd3, 3'd2, 32'h101, 32'h0), 1'b1, 32'h0, 1'b0, 1'b1);
      applyStimulus(mkOp(0, 1, 0, 5'd0, 3'd1, 32'h102, 32'h00001234), 1'b1, 32'h0, 1'b0, 1'b1);
      checkOutput("lw_mis_pulse", mis_seen, 1);
      applyStimulus(nop, 1'b1, 32'h0, 1'b0, 1'b1);
      checkOutput("sh_be", 32'(last_be), 32'hC);
      checkOutput("sh_wdata", last_wdata, 32'h12341234);

      clearSeen();
      applyStimulus(mkOp(1, 0, 1, 5'd4, 3'd2, 32'h200, 32'h0), 1'b0, 32'h0, 1'b0, 1'b1);
      repeat (6) applyStimulus(nop, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("to_berr", berr_seen, 1);
      checkOutput("to_stalls", stall_seen, TO);

      applyStimulus(mkOp(1, 0, 1, 5'd5, 3'd2, 32'h300, 32'h0), 1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(nop, 1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(nop, 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(nop, 1'b0, 32'h0, 1'b0, 1'b1);

      o = mkOp(0, 0, 1, 5'd7, 3'd0, 32'h55, 32'h0);
      applyStimulus(mkOp(1, 0, 1, 5'd6, 3'd2, 32'h400, 32'h0), 1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(o, 1'b0, 32'h0, 1'b1, 1'b1);
      applyStimulus(o, 1'b0, 32'h0, 1'b1, 1'b1);
      applyStimulus(o, 1'b1, 32'h11223344, 1'b1, 1'b1);
      applyStimulus(o, 1'b1, 32'h0, 1'b0, 1'b1);
      applyStimulus(nop, 1'b1, 32'h0, 1'b0, 1'b1);

      for (int i = 0; i < 600; i++) begin
         kind    = int'($urandom_range(0, 3));
         o       = '0;
         o.rd_op = (kind == 1) || (kind == 3);
         o.wr_op = (kind == 2);
         o.regw  = 1'($urandom_range(0, 1));
         o.rd    = 5'($urandom_range(0, 31));
         o.addr  = $urandom;
         o.data  = $urandom;
         if ($urandom_range(0, 4) == 0) begin
            o.f3 = 3'($urandom_range(0, 7));
         end else if (o.rd_op) begin
            case ($urandom_range(0, 4))
               0: o.f3 = 3'd0;
               1: o.f3 = 3'd1;
               2: o.f3 = 3'd2;
               3: o.f3 = 3'd4;
               default: o.f3 = 3'd5;
            endcase
         end else begin
            o.f3 = 3'($urandom_range(0, 2));
         end
         rdy = ((i % 60) >= 50) ? 1'b0 : ($urandom_range(0, 3) != 0);
         fl  = ($urandom_range(0, 9) == 0);
         rn  = ($urandom_range(0, 99) != 0);
         applyStimulus(o, rdy, $urandom, fl, rn);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
